// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the transmit arbiter slice.
package tx_arbiter_pkg;

  // Arbiter FSM: wait for work, strobe the transmitter, then track its
  // ready line going low (word taken) and high again (word sent).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } tx_arb_state_t;

  // Requester indices; lower index wins arbitration.
  localparam int REQ_SMPL   = 0;
  localparam int REQ_RDBACK = 1;
  localparam int REQ_META   = 2;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first one-hot picker with a valid flag.
module prio_enc #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] onehot_o,
  output logic         valid_o
);

  // Walk from index 0 upward and keep only the first set bit.
  always_comb begin
    logic found;
    found    = 1'b0;
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        onehot_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one word transmitter between NREQ requesters. Each request word
// waits in its own slot; the lowest pending index is launched when the
// transmitter is ready and the link is not paused by XOFF.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_stb_i,
  input  logic [NREQ*WIDTH-1:0] req_dat_i,
  output logic [NREQ-1:0]       req_busy_o,
  output logic [NREQ-1:0]       done_o,
  output logic [NREQ-1:0]       gnt_o,
  input  logic                  xon_i,
  input  logic                  xoff_i,
  input  logic                  tx_rdy_i,
  output logic                  tx_stb_o,
  output logic [WIDTH-1:0]      tx_o,
  output logic                  ovr_o
);

  tx_arb_state_t    state_q, state_d;
  logic [NREQ-1:0]  pend_q, pend_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] dat_q [NREQ];
  logic [WIDTH-1:0] dat_d [NREQ];
  logic [WIDTH-1:0] tx_q, tx_d;
  logic             tx_stb_q, tx_stb_d;
  logic             paused_q, paused_d;
  logic             ovr_q, ovr_d;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  pick;
  logic             pick_vld;
  logic [WIDTH-1:0] pick_dat;

  prio_enc #(
    .N(NREQ)
  ) u_prio (
    .req_i   (pend_q),
    .onehot_o(pick),
    .valid_o (pick_vld)
  );

  // Completion is seen combinationally so a slot can be refilled in the
  // very cycle its previous word finishes.
  always_comb begin
    done = '0;
    if (state_q == WAIT_HI && tx_rdy_i) begin
      done = gnt_q;
    end
  end

  // Select the word of the requester the priority encoder picked.
  always_comb begin
    pick_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_dat = dat_q[i];
      end
    end
  end

  // Slot capture: accept into an empty or just-finishing slot, else drop
  // the strobe and raise the sticky overrun flag.
  always_comb begin
    pend_d = pend_q & ~done;
    ovr_d  = ovr_q;
    for (int i = 0; i < NREQ; i++) begin
      dat_d[i] = dat_q[i];
      if (req_stb_i[i]) begin
        if (!pend_q[i] || done[i]) begin
          dat_d[i]  = req_dat_i[i*WIDTH +: WIDTH];
          pend_d[i] = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  // XOFF dominates XON so a simultaneous pair leaves the link paused.
  always_comb begin
    paused_d = paused_q;
    if (xoff_i) begin
      paused_d = 1'b1;
    end else if (xon_i) begin
      paused_d = 1'b0;
    end
  end

  // Launch/handshake FSM; grant and word stay locked until completion.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    tx_d     = tx_q;
    tx_stb_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld && !paused_q && tx_rdy_i) begin
          tx_d     = pick_dat;
          gnt_d    = pick;
          tx_stb_d = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_rdy_i) begin
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_rdy_i) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any transfer in progress immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      gnt_q    <= '0;
      tx_q     <= '0;
      tx_stb_q <= 1'b0;
      paused_q <= 1'b0;
      ovr_q    <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      gnt_q    <= gnt_d;
      tx_q     <= tx_d;
      tx_stb_q <= tx_stb_d;
      paused_q <= paused_d;
      ovr_q    <= ovr_d;
      for (int i = 0; i < NREQ; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign req_busy_o = pend_q;
  assign done_o     = done;
  assign gnt_o      = gnt_q;
  assign tx_stb_o   = tx_stb_q;
  assign tx_o       = tx_q;
  assign ovr_o      = ovr_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed and randomized checks for tx_arbiter with a small transmitter
// model and a per-slot scoreboard.
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NREQ-1:0]       req_stb_i;
  logic [NREQ*WIDTH-1:0] req_dat_i;
  logic [NREQ-1:0]       req_busy_o;
  logic [NREQ-1:0]       done_o;
  logic [NREQ-1:0]       gnt_o;
  logic                  xon_i;
  logic                  xoff_i;
  logic                  tx_rdy_i;
  logic                  tx_stb_o;
  logic [WIDTH-1:0]      tx_o;
  logic                  ovr_o;

  int checks = 0;
  int errors = 0;

  int          stbCount  = 0;
  int          doneCount = 0;
  logic        prevStb   = 1'b0;
  logic [2:0]  prevGnt   = 3'b000;
  logic [31:0] sentLog[$];
  int          doneLog[$];

  logic        autoTx    = 1'b0;
  logic        randLat   = 1'b0;
  int          txLat     = 3;
  int          txBusyCnt = 0;

  logic        sbOn = 1'b0;
  logic        expValid [NREQ];
  logic [31:0] expWord [NREQ];

  tx_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_stb_i (req_stb_i),
    .req_dat_i (req_dat_i),
    .req_busy_o(req_busy_o),
    .done_o    (done_o),
    .gnt_o     (gnt_o),
    .xon_i     (xon_i),
    .xoff_i    (xoff_i),
    .tx_rdy_i  (tx_rdy_i),
    .tx_stb_o  (tx_stb_o),
    .tx_o      (tx_o),
    .ovr_o     (ovr_o)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Last-resort guard so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] stb, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic xon, input logic xoff);
    req_stb_i = stb;
    req_dat_i = {w2, w1, w0};
    xon_i     = xon;
    xoff_i    = xoff;
  endtask

  task automatic applyIdle();
    applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // One clock: observe at the falling edge, then let the transmitter model
  // react just after the rising edge.
  task automatic stepCycle();
    @(negedge clk_i);
    if (!rst_i) begin
      checkOutput("gnt_onehot0", 64'($onehot0(gnt_o)), 64'd1);
      if (tx_stb_o) begin
        stbCount++;
        sentLog.push_back(tx_o);
        checkOutput("stb_only_from_idle", 64'({prevStb, prevGnt}), 64'd0);
        checkOutput("stb_has_gnt", 64'($onehot(gnt_o)), 64'd1);
        if (sbOn) begin
          for (int k = 0; k < NREQ; k++) begin
            if (gnt_o[k]) begin
              checkOutput("sb_slot_pending", 64'(expValid[k]), 64'd1);
              checkOutput("sb_word", 64'(tx_o), 64'(expWord[k]));
            end
          end
        end
      end
      if (done_o != 3'b000) begin
        doneCount++;
        checkOutput("done_matches_gnt", 64'(done_o), 64'(gnt_o));
        for (int k = 0; k < NREQ; k++) begin
          if (done_o[k]) begin
            doneLog.push_back(k);
            if (sbOn) expValid[k] = 1'b0;
          end
        end
      end
      prevStb = tx_stb_o;
      prevGnt = gnt_o;
    end else begin
      prevStb = 1'b0;
      prevGnt = 3'b000;
    end
    @(posedge clk_i);
    #1;
    if (autoTx) begin
      if (txBusyCnt > 0) begin
        txBusyCnt--;
        tx_rdy_i = (txBusyCnt == 0);
      end else if (tx_stb_o) begin
        txBusyCnt = randLat ? int'($urandom_range(6, 2)) : txLat;
      end
    end
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (doneCount < target && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 64'(doneCount >= target), 64'd1);
  endtask

  initial begin
    int baseStb;
    int baseDone;
    int accepted;
    logic [2:0]  stb;
    logic [31:0] w [NREQ];
    logic        anyLeft;
    int          n;

    rst_i = 1'b1;
    tx_rdy_i = 1'b1;
    applyIdle();
    for (int i = 0; i < NREQ; i++) begin
      expValid[i] = 1'b0;
      expWord[i]  = 32'h0;
    end
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_tx_stb", 64'(tx_stb_o), 64'd0);
    checkOutput("rst_gnt", 64'(gnt_o), 64'd0);
    checkOutput("rst_busy", 64'(req_busy_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_tx_o", 64'(tx_o), 64'd0);
    checkOutput("rst_ovr", 64'(ovr_o), 64'd0);
    rst_i = 1'b0;
    repeat (2) stepCycle();

    // Single request, transmitter handshake driven by hand.
    applyStimulus(3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    stepCycle(); applyIdle(); #1;
    checkOutput("t1_busy_c1", 64'(req_busy_o), 64'b010);
    checkOutput("t1_no_stb_c1", 64'(tx_stb_o), 64'd0);
    stepCycle(); #1;
    checkOutput("t1_stb_c2", 64'(tx_stb_o), 64'd1);
    checkOutput("t1_tx_o_c2", 64'(tx_o), 64'hDEADBEEF);
    checkOutput("t1_gnt_c2", 64'(gnt_o), 64'b010);
    stepCycle(); tx_rdy_i = 1'b0; #1;
    checkOutput("t1_stb_pulse_c3", 64'(tx_stb_o), 64'd0);
    checkOutput("t1_gnt_c3", 64'(gnt_o), 64'b010);
    stepCycle(); stepCycle();
    stepCycle(); tx_rdy_i = 1'b1; #1;
    checkOutput("t1_done_c6", 64'(done_o), 64'b010);
    checkOutput("t1_busy_c6", 64'(req_busy_o), 64'b010);
    stepCycle(); #1;
    checkOutput("t1_busy_c7", 64'(req_busy_o), 64'b000);
    checkOutput("t1_gnt_c7", 64'(gnt_o), 64'b000);
    checkOutput("t1_done_c7", 64'(done_o), 64'b000);

    // Simultaneous strobes are served in priority order.
    autoTx = 1'b1; randLat = 1'b0; txLat = 3;
    stepCycle();
    sentLog.delete(); doneLog.delete();
    baseStb = stbCount; baseDone = doneCount;
    applyStimulus(3'b101, 32'h11, 32'h0, 32'h22, 1'b0, 1'b0);
    stepCycle(); applyIdle();
    waitDone(baseDone + 2, 60, "t2_both_done");
    repeat (5) stepCycle();
    checkOutput("t2_stb_count", 64'(stbCount - baseStb), 64'd2);
    checkOutput("t2_sent_size", 64'(sentLog.size()), 64'd2);
    if (sentLog.size() >= 2 && doneLog.size() >= 2) begin
      checkOutput("t2_first_word", 64'(sentLog[0]), 64'h11);
      checkOutput("t2_second_word", 64'(sentLog[1]), 64'h22);
      checkOutput("t2_first_done", 64'(doneLog[0]), 64'd0);
      checkOutput("t2_second_done", 64'(doneLog[1]), 64'd2);
    end

    // XOFF holds new launches until XON; XON+XOFF together stays paused.
    sentLog.delete();
    baseStb = stbCount; baseDone = doneCount;
    applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(3'b001, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0);
    stepCycle(); applyIdle();
    repeat (50) stepCycle();
    #1;
    checkOutput("t3_paused_no_stb", 64'(stbCount - baseStb), 64'd0);
    checkOutput("t3_paused_busy", 64'(req_busy_o[0]), 64'd1);
    applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    stepCycle(); applyIdle();
    stepCycle(); #1;
    checkOutput("t3_xon_launch", 64'(tx_stb_o), 64'd1);
    checkOutput("t3_xon_word", 64'(tx_o), 64'h33);
    waitDone(baseDone + 1, 40, "t3_first_done");
    baseStb = stbCount; baseDone = doneCount;
    applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(3'b001, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
    stepCycle(); applyIdle();
    repeat (5) stepCycle();
    applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    stepCycle(); applyIdle();
    repeat (20) stepCycle();
    #1;
    checkOutput("t3_both_stays_paused", 64'(stbCount - baseStb), 64'd0);
    checkOutput("t3_both_busy", 64'(req_busy_o[0]), 64'd1);
    applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    stepCycle(); applyIdle();
    waitDone(baseDone + 1, 40, "t3_second_done");
    checkOutput("t3_second_word", 64'(sentLog.size() > 0 ? sentLog[$] : 32'h0), 64'h44);

    // Overrun on a busy slot, refill accepted in the completion cycle.
    autoTx = 1'b0; txBusyCnt = 0; tx_rdy_i = 1'b1;
    stepCycle();
    checkOutput("t4_ovr_clear_before", 64'(ovr_o), 64'd0);
    applyStimulus(3'b010, 32'h0, 32'hAAAA0001, 32'h0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(3'b010, 32'h0, 32'hBBBB0002, 32'h0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(3'b010, 32'h0, 32'hCCCC0003, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("t4_launch", 64'(tx_stb_o), 64'd1);
    checkOutput("t4_ovr_set", 64'(ovr_o), 64'd1);
    stepCycle(); applyIdle(); tx_rdy_i = 1'b0; #1;
    checkOutput("t4_ovr_sticky", 64'(ovr_o), 64'd1);
    checkOutput("t4_first_word_kept", 64'(tx_o), 64'hAAAA0001);
    stepCycle();
    stepCycle(); tx_rdy_i = 1'b1;
    applyStimulus(3'b010, 32'h0, 32'hDDDD0004, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("t4_done", 64'(done_o), 64'b010);
    stepCycle(); applyIdle(); #1;
    checkOutput("t4_recaptured", 64'(req_busy_o), 64'b010);
    checkOutput("t4_gnt_released", 64'(gnt_o), 64'b000);
    checkOutput("t4_ovr_still_set", 64'(ovr_o), 64'd1);
    stepCycle(); #1;
    checkOutput("t4_refill_launch", 64'(tx_stb_o), 64'd1);
    checkOutput("t4_refill_word", 64'(tx_o), 64'hDDDD0004);
    stepCycle(); tx_rdy_i = 1'b0;
    stepCycle(); tx_rdy_i = 1'b1; #1;
    checkOutput("t4_refill_done", 64'(done_o), 64'b010);
    stepCycle();

    // Asynchronous reset in the middle of a transfer.
    applyStimulus(3'b100, 32'h0, 32'h0, 32'h55, 1'b0, 1'b0);
    stepCycle(); applyIdle();
    stepCycle();
    stepCycle(); #1;
    checkOutput("t5_gnt_before_rst", 64'(gnt_o), 64'b100);
    checkOutput("t5_busy_before_rst", 64'(req_busy_o), 64'b100);
    rst_i = 1'b1; #1;
    checkOutput("t5_rst_stb", 64'(tx_stb_o), 64'd0);
    checkOutput("t5_rst_gnt", 64'(gnt_o), 64'd0);
    checkOutput("t5_rst_busy", 64'(req_busy_o), 64'd0);
    checkOutput("t5_rst_ovr", 64'(ovr_o), 64'd0);
    checkOutput("t5_rst_done", 64'(done_o), 64'd0);
    stepCycle(); rst_i = 1'b0;
    stepCycle();
    autoTx = 1'b1; txLat = 4;
    baseDone = doneCount;
    applyStimulus(3'b001, 32'h66, 32'h0, 32'h0, 1'b0, 1'b0);
    stepCycle(); applyIdle();
    waitDone(baseDone + 1, 40, "t5_fresh_done");
    checkOutput("t5_fresh_word", 64'(sentLog.size() > 0 ? sentLog[$] : 32'h0), 64'h66);
    checkOutput("t5_ovr_after", 64'(ovr_o), 64'd0);

    // Randomized traffic against the per-slot scoreboard.
    repeat (3) stepCycle();
    sbOn = 1'b1; randLat = 1'b1;
    accepted = 0;
    baseStb = stbCount; baseDone = doneCount;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      stb = 3'b000;
      for (int i = 0; i < NREQ; i++) begin
        w[i] = 32'h0;
        if (!expValid[i] && $urandom_range(7, 0) == 0) begin
          stb[i]      = 1'b1;
          w[i]        = $urandom;
          expValid[i] = 1'b1;
          expWord[i]  = w[i];
          accepted++;
        end
      end
      applyStimulus(stb, w[0], w[1], w[2], ($urandom_range(29, 0) == 0), ($urandom_range(99, 0) == 0));
      stepCycle();
    end
    applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    stepCycle(); applyIdle();
    n = 0;
    anyLeft = 1'b1;
    while (anyLeft && n < 500) begin
      stepCycle();
      n++;
      anyLeft = expValid[0] | expValid[1] | expValid[2];
    end
    checkOutput("t6_drained", 64'(anyLeft), 64'd0);
    checkOutput("t6_launch_count", 64'(stbCount - baseStb), 64'(accepted));
    checkOutput("t6_done_count", 64'(doneCount - baseDone), 64'(accepted));
    checkOutput("t6_no_overrun", 64'(ovr_o), 64'd0);
    checkOutput("t6_idle_busy", 64'(req_busy_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
